// File: rtl/flow_tag_arbiter.sv
// flow_tag_arbiter
//   Round-robin arbiter that merges FLUX independent flows into one shared
//   downstream FIFO. Each word that is accepted is tagged with the index of
//   its flow. The tag goes in the top TAG_WIDTH bits and the payload goes in
//   the low PAYLOAD bits.
//
//   The output holds a single register slot. A new word can be accepted when
//   the slot is empty, or when the word in the slot is being written this
//   cycle. This allows one word per cycle while the FIFO is not full.
//
//   Optional feature: define FLOW_TAG_ARBITER_CNT_EN to add a saturating
//   16-bit accepted-word counter for each flow on cnt_out. When it is not
//   defined, cnt_out is tied to zero and no counter logic is built.
//
// Ports
//   ck        : clock; all state changes on the rising edge
//   rst       : synchronous active-high reset
//   in_valid  : [FLUX] a word is available on each flow
//   in_data   : [FLUX*PAYLOAD] payload for flow i at [i*PAYLOAD +: PAYLOAD]
//   in_ready  : [FLUX] accept strobe for each flow; combinational, one-hot or zero
//   full      : downstream FIFO is full
//   wr        : registered write strobe to the FIFO
//   datain    : [WIDTH] registered tagged word {tag, payload}
//   cnt_out   : [FLUX*16] accepted-word counter for each flow (zero when the
//               counter feature is disabled)
//
// PAYLOAD = WIDTH - $clog2(FLUX) must be at least 1.
module flow_tag_arbiter #(
  parameter  int WIDTH     = 8,
  parameter  int FLUX      = 2,
  localparam int TAG_WIDTH = $clog2(FLUX),
  localparam int PAYLOAD   = WIDTH - TAG_WIDTH
) (
  input  logic                    ck,
  input  logic                    rst,
  input  logic [FLUX-1:0]         in_valid,
  input  logic [FLUX*PAYLOAD-1:0] in_data,
  output logic [FLUX-1:0]         in_ready,
  input  logic                    full,
  output logic                    wr,
  output logic [WIDTH-1:0]        datain,
  output logic [FLUX*16-1:0]      cnt_out
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state, state_nxt;
  logic [TAG_WIDTH-1:0]   rr_ptr;
  logic [TAG_WIDTH-1:0]   grant_idx;
  logic                   grant_found;
  logic                   slot_free;
  logic                   accept;
  logic [PAYLOAD-1:0]     grant_payload;
  logic [WIDTH-1:0]       word_p1;

  // Round-robin search. The search starts just after the last granted flow
  // and wraps around, so the flow served most recently has the lowest
  // priority. Only in_valid is examined, which keeps in_ready independent
  // of in_data.
  always_comb begin
    int cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= FLUX; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= FLUX) cand = cand - FLUX;
      if (!grant_found && in_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = TAG_WIDTH'(cand);
      end
    end
  end

  assign slot_free     = (state == IDLE) || ((state == SEND) && !full);
  assign accept        = slot_free && grant_found && !rst;
  assign in_ready      = accept ? (FLUX'(1) << grant_idx) : '0;
  assign grant_payload = in_data[int'(grant_idx)*PAYLOAD +: PAYLOAD];

  // FSM: IDLE means the output slot is empty; SEND means the slot holds a word.
  always_ff @(posedge ck) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept)                         state_nxt = SEND;
    else if ((state == SEND) && !full)  state_nxt = IDLE;
  end

  // Stage p1: output word register and round-robin pointer.
  // Reset clears the pending word, so it is never written.
  always_ff @(posedge ck) begin
    if (rst) begin
      word_p1 <= '0;
      rr_ptr  <= TAG_WIDTH'(FLUX - 1);
    end else if (accept) begin
      word_p1 <= {grant_idx, grant_payload};
      rr_ptr  <= grant_idx;
    end
  end

  assign wr     = (state == SEND);
  assign datain = word_p1;

`ifdef FLOW_TAG_ARBITER_CNT_EN
  logic [15:0] cnt [FLUX];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge ck) begin
    for (int i = 0; i < FLUX; i++) begin
      if (rst)                                       cnt[i] <= '0;
      else if (accept && (grant_idx == TAG_WIDTH'(i))) cnt[i] <= sat_inc(cnt[i]);
    end
  end

  for (genvar gi = 0; gi < FLUX; gi++) begin : g_cnt
    assign cnt_out[gi*16 +: 16] = cnt[gi];
  end
`else
  assign cnt_out = '0;
`endif

endmodule
